if_id_queue: RTL
================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of the pc field.
REQ-002 SHALL have parameter ILEN, default 32: width of the instruction field.
REQ-003 SHALL have parameter DEPTH, default 2: entry count; legal values are powers of two ≥ 2.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port flush_i, input, 1 bit: discard all buffered entries.
REQ-007 SHALL have port in_valid_i, input, 1 bit: fetch offers an entry.
REQ-008 SHALL have port in_ready_o, output, 1 bit: queue can accept an entry.
REQ-009 SHALL have port in_pc_i, input, XLEN bits: pc of the offered instruction.
REQ-010 SHALL have port in_instr_i, input, ILEN bits: the offered instruction word.
REQ-011 SHALL have port out_valid_o, output, 1 bit: head entry is present.
REQ-012 SHALL have port out_ready_i, input, 1 bit: decode consumes the head entry.
REQ-013 SHALL have port out_pc_o, output, XLEN bits: pc of the head entry.
REQ-014 SHALL have port out_instr_o, output, ILEN bits: instruction of the head entry.
REQ-015 SHALL have port count_o, output, $clog2(DEPTH+1) bits: number of occupied entries.

Function
REQ-016 SHALL push {in_pc_i, in_instr_i} at a rising edge when in_valid_i=1, in_ready_o=1, flush_i=0 and rst_i=0.
REQ-017 SHALL pop the head at a rising edge when out_valid_o=1, out_ready_i=1, flush_i=0 and rst_i=0.
REQ-018 SHALL deliver entries in push order (FIFO), never duplicating or dropping an entry outside flush or reset.
REQ-019 SHALL drive in_ready_o = (count_o < DEPTH), depending only on registered state with no combinational path from out_ready_i.
REQ-020 SHALL drive out_valid_o = (count_o != 0), registered, with no combinational path from in_valid_i.
REQ-021 SHALL have a latency of exactly one cycle: an entry pushed into an empty queue at edge N appears on the outputs after edge N.
REQ-022 SHALL, on a simultaneous push and pop, leave count_o unchanged and advance both pointers; this is legal at any count from 1 to DEPTH-1.
REQ-023 SHALL accept no push when full (count_o=DEPTH) and SHALL let a pop in that cycle lower count_o to DEPTH-1, with in_ready_o=1 on the next cycle.
REQ-024 SHALL ignore a pop request when empty, with count_o holding at 0.
REQ-025 SHALL wrap read and write pointers modulo DEPTH, without a bubble at the wrap point.
REQ-026 SHALL, when flush_i=1 at an edge, set count_o=0, set both pointers equal, and discard any push or pop in that cycle; out_valid_o=0 in the next cycle.
REQ-027 SHALL let flush_i=1 with rst_i=0 leave in_ready_o=1 in the following cycle.
REQ-028 SHALL drive out_pc_o and out_instr_o to all-zeros when out_valid_o=0 and to the head entry otherwise.
REQ-029 SHALL keep count_o within 0..DEPTH in every cycle.

Reset
REQ-030 SHALL, when rst_i=1 at a rising edge, set count_o=0 and both pointers to 0; reset takes priority over flush, push and pop.
REQ-031 SHALL have these values after reset: in_ready_o=1, out_valid_o=0, out_pc_o=0, out_instr_o=0, count_o=0.
REQ-032 SHALL let reset asserted mid-stream with the queue partially full discard all entries, with no stale entry ever appearing after reset.
REQ-033 SHALL leave the entry storage without reset, with no output exposing it while out_valid_o=0.

Verification
REQ-034 SHALL cover: after reset, push pc=0x100/instr=0x00500093 into the empty queue -> next cycle out_valid_o=1, out_pc_o=0x100, count_o=1.
REQ-035 SHALL cover: out_ready_i=0 with DEPTH=2, push 0x100 and 0x104 -> count_o=2, in_ready_o=0; a third push is held by the source and the held offer is accepted after one pop.
REQ-036 SHALL cover: with count_o=1, push and pop in the same cycle over 8 cycles -> count_o stays 1, outputs show pcs 0x100..0x11C in order, and pointers wrap cleanly.
REQ-037 SHALL cover: queue full with flush_i=1 and in_valid_i=1 in the same cycle -> next cycle count_o=0, out_valid_o=0, out_pc_o=0, and the offered entry never appears.
REQ-038 SHALL cover: rst_i=1 with count_o=1 -> next cycle all outputs at reset values, and the first push after reset is the first entry out.
REQ-039 SHALL cover: random valid/ready over 10k cycles at DEPTH=4, checked against a reference model -> output sequence equals input sequence, with no overflow or underflow.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry FIFO of {pc, instr} pairs with
// valid/ready handshakes on both sides, flush, and registered occupancy.
module if_id_queue #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [XLEN-1:0]            in_pc_i,
  input  logic [ILEN-1:0]            in_instr_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [XLEN-1:0]            out_pc_o,
  output logic [ILEN-1:0]            out_instr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] r_pc_mem    [DEPTH];
  logic [ILEN-1:0] r_instr_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  // Both handshake flags come purely from the occupancy register.
  assign w_in_ready  = (r_count < CW'(DEPTH));
  assign w_out_valid = (r_count != '0);

  assign w_push = in_valid_i & w_in_ready & ~flush_i & ~rst_i;
  assign w_pop  = w_out_valid & out_ready_i & ~flush_i & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; the output mux below hides it whenever empty.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= in_pc_i;
      r_instr_mem[r_wr_ptr] <= in_instr_i;
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = w_out_valid;
  assign count_o     = r_count;
  assign out_pc_o    = w_out_valid ? r_pc_mem[r_rd_ptr]    : '0;
  assign out_instr_o = w_out_valid ? r_instr_mem[r_rd_ptr] : '0;

endmodule
